// File: rtl/k12a_fetch_squash_pkg.sv
`default_nettype none
// ============================================================================
// Package     : k12a_fetch_squash_pkg
// Description : Shared k12a types for the fetch/squash sequencer: skip
//               register select codes, fetch state encoding, default
//               constants and a small state-classification helper.
// Revision    : 1.0 - initial release
// ============================================================================
package k12a_fetch_squash_pkg;

  // Data source selected for the next write into the skip register.
  typedef enum logic [1:0] {
    SKIP_SEL_0 = 2'd0,  // clear skip
    SKIP_SEL_1 = 2'd1,  // set skip
    SKIP_SEL_C = 2'd2,  // load from carry
    SKIP_SEL_Z = 2'd3   // load from zero
  } skip_sel_t;

  typedef enum logic [2:0] {
    FETCH_HI = 3'd0,
    FETCH_LO = 3'd1,
    IMM_HI   = 3'd2,
    IMM_LO   = 3'd3,
    DECIDE   = 3'd4,
    EXECUTE  = 3'd5,
    SQUASH   = 3'd6
  } fetch_state_t;

  localparam logic [15:0] RESET_PC_DEFAULT   = 16'h0000;
  localparam logic [3:0]  IMM_OPCODE_DEFAULT = 4'hF;

  // True for every state that owns the memory bus.
  function automatic logic is_bus_state(input fetch_state_t s);
    return (s == FETCH_HI) || (s == FETCH_LO) || (s == IMM_HI) || (s == IMM_LO);
  endfunction

endpackage : k12a_fetch_squash_pkg
`default_nettype wire

// File: rtl/k12a_fetch_squash.sv
`default_nettype none
// ============================================================================
// Module      : k12a_fetch_squash
// Description : Instruction fetch sequencer. Fetches a big-endian 16-bit
//               instruction (plus an optional 16-bit immediate) over the
//               8-bit memory bus, then either hands it to execute or squashes
//               it when the skip flag is set, clearing skip in that cycle.
//               Sole driver of skip_sel/skip_store; forwards execute requests.
// Config      : K12A_SQUASH_COUNT_EN adds output squash_count (saturating
//               count of squashed instructions).
// Ports       : cpu_clock/reset      - clock, synchronous active-high reset
//               mem_addr/mem_read    - byte read request (addr = pc)
//               mem_rdata/mem_ready  - read data / completion
//               pc, inst, imm        - fetch address and fetched words
//               inst_valid/exec_done - handshake with execute stage
//               pc_load/pc_load_value- jump on exec_done
//               exec_skip_store/sel  - execute-stage skip write request
//               skip                 - current skip flag
//               skip_sel/skip_store  - skip register write port
// Revision    : 1.0 - initial release
// ============================================================================
module k12a_fetch_squash
  import k12a_fetch_squash_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [3:0]  IMM_OPCODE = IMM_OPCODE_DEFAULT
) (
  input  logic        cpu_clock,
  input  logic        reset,
  output logic [15:0] mem_addr,
  output logic        mem_read,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] pc,
  output logic [15:0] inst,
  output logic [15:0] imm,
  output logic        inst_valid,
  input  logic        exec_done,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  input  logic        exec_skip_store,
  input  logic [1:0]  exec_skip_sel,
  input  logic        skip,
  output logic [1:0]  skip_sel,
  output logic        skip_store
`ifdef K12A_SQUASH_COUNT_EN
  ,
  output logic [15:0] squash_count
`endif
);

  fetch_state_t state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  inst_q, inst_d;
  logic [15:0]  imm_q, imm_d;
  skip_sel_t    skip_sel_w;

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      state_q <= FETCH_HI;
      pc_q    <= RESET_PC;
      inst_q  <= 16'h0000;
      imm_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      imm_q   <= imm_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    imm_d      = imm_q;
    skip_store = exec_skip_store;
    skip_sel_w = skip_sel_t'(exec_skip_sel);

    case (state_q)
      FETCH_HI: begin
        if (mem_ready) begin
          inst_d[15:8] = mem_rdata;
          pc_d         = pc_q + 16'd1;
          state_d      = FETCH_LO;
        end
      end
      FETCH_LO: begin
        if (mem_ready) begin
          inst_d[7:0] = mem_rdata;
          pc_d        = pc_q + 16'd1;
          // High byte is already registered, so the opcode is known here.
          if (inst_q[15:12] == IMM_OPCODE) begin
            state_d = IMM_HI;
          end else begin
            imm_d   = 16'h0000;
            state_d = DECIDE;
          end
        end
      end
      IMM_HI: begin
        if (mem_ready) begin
          imm_d[15:8] = mem_rdata;
          pc_d        = pc_q + 16'd1;
          state_d     = IMM_LO;
        end
      end
      IMM_LO: begin
        if (mem_ready) begin
          imm_d[7:0] = mem_rdata;
          pc_d       = pc_q + 16'd1;
          state_d    = DECIDE;
        end
      end
      DECIDE: begin
        state_d = skip ? SQUASH : EXECUTE;
      end
      EXECUTE: begin
        if (exec_done) begin
          if (pc_load) begin
            pc_d = pc_load_value;
          end
          state_d = FETCH_HI;
        end
      end
      SQUASH: begin
        // Clearing skip takes priority; execute is idle in this state.
        skip_store = 1'b1;
        skip_sel_w = SKIP_SEL_0;
        state_d    = FETCH_HI;
      end
      default: begin
        state_d = FETCH_HI;
      end
    endcase

    if (reset) begin
      skip_store = 1'b0;
      skip_sel_w = SKIP_SEL_0;
    end
  end

  // Reset gating keeps the bus quiet while the state register is reloading.
  assign mem_read   = is_bus_state(state_q) && !reset;
  assign mem_addr   = pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign imm        = imm_q;
  assign inst_valid = (state_q == EXECUTE);
  assign skip_sel   = skip_sel_w;

`ifdef K12A_SQUASH_COUNT_EN
  logic [15:0] squash_count_q;

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      squash_count_q <= 16'h0000;
    end else if ((state_q == SQUASH) && (squash_count_q != 16'hFFFF)) begin
      squash_count_q <= squash_count_q + 16'd1;
    end
  end

  assign squash_count = squash_count_q;
`endif

endmodule : k12a_fetch_squash
`default_nettype wire

// File: tb/tb_k12a_fetch_squash.sv
`default_nettype none
// ============================================================================
// Module      : tb_k12a_fetch_squash
// Description : Self-checking bench for k12a_fetch_squash. A byte-array
//               memory model answers bus reads; expected instructions are
//               queued as programs are loaded and popped when inst_valid rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_k12a_fetch_squash;

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] imm;
    logic [15:0] pc;
  } exp_t;

  logic        cpu_clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mem_addr;
  logic        mem_read;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic [15:0] pc;
  logic [15:0] inst;
  logic [15:0] imm;
  logic        inst_valid;
  logic        exec_done = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_value = 16'h0000;
  logic        exec_skip_store = 1'b0;
  logic [1:0]  exec_skip_sel = 2'd0;
  logic        skip = 1'b0;
  logic [1:0]  skip_sel;
  logic        skip_store;
`ifdef K12A_SQUASH_COUNT_EN
  logic [15:0] squash_count;
`endif

  logic [7:0] mem [0:65535];
  logic       stall = 1'b0;
  exp_t       sb_q[$];
  int         total = 0;
  int         bad = 0;

  assign mem_rdata = mem[mem_addr];
  assign mem_ready = mem_read && !stall;

  always #5 cpu_clock = ~cpu_clock;

  k12a_fetch_squash dut (
    .cpu_clock       (cpu_clock),
    .reset           (reset),
    .mem_addr        (mem_addr),
    .mem_read        (mem_read),
    .mem_rdata       (mem_rdata),
    .mem_ready       (mem_ready),
    .pc              (pc),
    .inst            (inst),
    .imm             (imm),
    .inst_valid      (inst_valid),
    .exec_done       (exec_done),
    .pc_load         (pc_load),
    .pc_load_value   (pc_load_value),
    .exec_skip_store (exec_skip_store),
    .exec_skip_sel   (exec_skip_sel),
    .skip            (skip),
    .skip_sel        (skip_sel),
    .skip_store      (skip_store)
`ifdef K12A_SQUASH_COUNT_EN
    ,
    .squash_count    (squash_count)
`endif
  );

  // Two reset cycles, then release just after a rising edge so the next
  // falling edge is fetch cycle 1.
  task automatic do_reset();
    @(posedge cpu_clock);
    #1;
    reset = 1'b1;
    skip = 1'b0;
    stall = 1'b0;
    exec_done = 1'b0;
    pc_load = 1'b0;
    exec_skip_store = 1'b0;
    @(posedge cpu_clock);
    @(posedge cpu_clock);
    #1;
    reset = 1'b0;
  endtask

  // Scoreboard consumer: wait (bounded) for inst_valid, pop, compare.
  task automatic sb_consume(input string name, input int exp_lat);
    int   cnt = 0;
    bit   got = 1'b0;
    exp_t e;
    for (int i = 1; i <= 40; i++) begin
      @(negedge cpu_clock);
      if (inst_valid === 1'b1) begin
        got = 1'b1;
        cnt = i;
        break;
      end
    end
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL %s_sb_empty: scoreboard had no expectation", name);
      return;
    end
    e = sb_q.pop_front();
    if (!got) begin
      bad++;
      $display("FAIL %s_timeout: inst_valid never 1 within 40 cycles", name);
      return;
    end
    if (exp_lat > 0) begin
      total++;
      if (cnt != exp_lat) begin
        bad++;
        $display("FAIL %s_latency: got %0d cycles, want %0d", name, cnt, exp_lat);
      end
    end
    total++;
    if (inst !== e.inst) begin
      bad++;
      $display("FAIL %s_inst: got %h want %h", name, inst, e.inst);
    end
    total++;
    if (imm !== e.imm) begin
      bad++;
      $display("FAIL %s_imm: got %h want %h", name, imm, e.imm);
    end
    total++;
    if (pc !== e.pc) begin
      bad++;
      $display("FAIL %s_pc: got %h want %h", name, pc, e.pc);
    end
  endtask

  // Called at a falling edge with inst_valid high; accepts for one cycle.
  task automatic accept(input logic load, input logic [15:0] target);
    exec_done = 1'b1;
    pc_load = load;
    pc_load_value = target;
    @(posedge cpu_clock);
    #1;
    exec_done = 1'b0;
    pc_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    exec_skip_store = 1'b1;
    exec_skip_sel = 2'd2;
    @(posedge cpu_clock);
    @(posedge cpu_clock);
    @(negedge cpu_clock);
    total++;
    if (pc !== 16'h0000) begin bad++; $display("FAIL reset_pc: got %h want 0000", pc); end
    total++;
    if (inst !== 16'h0000 || imm !== 16'h0000) begin
      bad++; $display("FAIL reset_inst_imm: got %h/%h want 0000/0000", inst, imm);
    end
    total++;
    if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
    total++;
    if (mem_read !== 1'b0) begin bad++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
    total++;
    if (skip_store !== 1'b0 || skip_sel !== 2'd0) begin
      bad++; $display("FAIL reset_skip_out: got %b/%0d want 0/0", skip_store, skip_sel);
    end
    exec_skip_store = 1'b0;
    exec_skip_sel = 2'd0;
    @(posedge cpu_clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_plain();
    sb_q.push_back('{inst: 16'h1234, imm: 16'h0000, pc: 16'h0002});
    sb_consume("plain", 4);
    accept(1'b0, 16'h0000);
    @(negedge cpu_clock);
    total++;
    if (inst_valid !== 1'b0 || mem_read !== 1'b1 || mem_addr !== 16'h0002) begin
      bad++;
      $display("FAIL plain_next_fetch: valid=%b read=%b addr=%h want 0/1/0002",
               inst_valid, mem_read, mem_addr);
    end
  endtask

  task automatic test_imm();
    mem[0] = 8'hF0; mem[1] = 8'h00; mem[2] = 8'hAB; mem[3] = 8'hCD;
    do_reset();
    sb_q.push_back('{inst: 16'hF000, imm: 16'hABCD, pc: 16'h0004});
    sb_consume("imm", 6);
    accept(1'b0, 16'h0000);
    @(negedge cpu_clock);
    total++;
    if (mem_addr !== 16'h0004 || mem_read !== 1'b1) begin
      bad++; $display("FAIL imm_next_fetch: addr=%h read=%b want 0004/1", mem_addr, mem_read);
    end
  endtask

  task automatic test_squash();
    int  valid_seen = 0;
    bit  squashed = 1'b0;
    mem[0] = 8'hF0; mem[1] = 8'h00; mem[2] = 8'hAB; mem[3] = 8'hCD;
    mem[4] = 8'h12; mem[5] = 8'h34;
    do_reset();
    skip = 1'b1;
    // Execute keeps requesting a set; the squash cycle must override it.
    exec_skip_store = 1'b1;
    exec_skip_sel = 2'd1;
    for (int i = 0; i < 20; i++) begin
      @(negedge cpu_clock);
      if (inst_valid === 1'b1) valid_seen++;
      if (skip_store === 1'b1 && skip_sel === 2'd0) begin
        squashed = 1'b1;
        break;
      end
    end
    @(posedge cpu_clock);
    #1;
    skip = 1'b0;  // skip register takes the clear
    exec_skip_store = 1'b0;
    total++;
    if (!squashed) begin bad++; $display("FAIL squash_clear: no skip_store with SKIP_SEL_0 seen"); end
    total++;
    if (valid_seen != 0) begin bad++; $display("FAIL squash_valid: inst_valid high %0d cycles want 0", valid_seen); end
    @(negedge cpu_clock);
    total++;
    if (mem_addr !== 16'h0004 || mem_read !== 1'b1) begin
      bad++; $display("FAIL squash_next_fetch: addr=%h read=%b want 0004/1", mem_addr, mem_read);
    end
    total++;
    if (skip_store !== 1'b0) begin bad++; $display("FAIL squash_one_cycle: skip_store=%b want 0", skip_store); end
`ifdef K12A_SQUASH_COUNT_EN
    total++;
    if (squash_count !== 16'd1) begin bad++; $display("FAIL squash_count: got %0d want 1", squash_count); end
`endif
    sb_q.push_back('{inst: 16'h1234, imm: 16'h0000, pc: 16'h0006});
    sb_consume("after_squash", 3);
    accept(1'b0, 16'h0000);
  endtask

  task automatic test_wrap();
    mem[16'hFFFF] = 8'h56; mem[0] = 8'h12; mem[1] = 8'h34;
    do_reset();
    sb_q.push_back('{inst: 16'h1234, imm: 16'h0000, pc: 16'h0002});
    sb_consume("wrap_pre", 4);
    accept(1'b1, 16'hFFFF);
    @(negedge cpu_clock);
    total++;
    if (mem_addr !== 16'hFFFF || pc !== 16'hFFFF) begin
      bad++; $display("FAIL wrap_jump: addr=%h pc=%h want FFFF/FFFF", mem_addr, pc);
    end
    sb_q.push_back('{inst: 16'h5612, imm: 16'h0000, pc: 16'h0001});
    sb_consume("wrap", 3);
    accept(1'b0, 16'h0000);
  endtask

  task automatic test_forward();
    logic [1:0] sel;
    for (int i = 0; i < 4; i++) begin
      @(negedge cpu_clock);
      sel = 2'(i);
      exec_skip_store = 1'b1;
      exec_skip_sel = sel;
      #2;
      total++;
      if (skip_store !== 1'b1 || skip_sel !== sel) begin
        bad++; $display("FAIL forward_%0d: got %b/%0d want 1/%0d", i, skip_store, skip_sel, sel);
      end
    end
    exec_skip_store = 1'b0;
    #2;
    total++;
    if (skip_store !== 1'b0) begin bad++; $display("FAIL forward_idle: skip_store=%b want 0", skip_store); end
  endtask

  task automatic test_stall_reset();
    mem[0] = 8'h12; mem[1] = 8'h34;
    do_reset();
    @(posedge cpu_clock);  // FETCH_HI completes; now in FETCH_LO
    #1;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge cpu_clock);
      total++;
      if (mem_read !== 1'b1 || mem_addr !== 16'h0001 || inst_valid !== 1'b0) begin
        bad++;
        $display("FAIL stall_%0d: read=%b addr=%h valid=%b want 1/0001/0", i, mem_read, mem_addr, inst_valid);
      end
    end
    @(posedge cpu_clock);
    #1;
    reset = 1'b1;
    stall = 1'b0;
    @(posedge cpu_clock);
    @(negedge cpu_clock);
    total++;
    if (pc !== 16'h0000 || inst_valid !== 1'b0 || mem_read !== 1'b0) begin
      bad++;
      $display("FAIL stall_reset: pc=%h valid=%b read=%b want 0000/0/0", pc, inst_valid, mem_read);
    end
    @(posedge cpu_clock);
    #1;
    reset = 1'b0;
    sb_q.push_back('{inst: 16'h1234, imm: 16'h0000, pc: 16'h0002});
    sb_consume("stall_restart", 4);
    accept(1'b0, 16'h0000);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[0] = 8'h12;
    mem[1] = 8'h34;
    test_reset();
    test_plain();
    test_imm();
    test_squash();
    test_wrap();
    test_forward();
    test_stall_reset();
    total++;
    if (sb_q.size() != 0) begin bad++; $display("FAIL sb_leftover: %0d entries unconsumed", sb_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_k12a_fetch_squash
`default_nettype wire
